// File: rtl/flash_se_resp.sv
// rtl/flash_se_resp.sv - SPI-flash responder for WREN / SE / RDSR with an erase timer
//
// Purpose: stands in for a serial flash on the far side of the flash command
// controllers. SPI mode 0, MSB first, oversampled in the sys_clk domain.
// Decodes WREN (0x06), SE (0xD8 + 24-bit address) and RDSR (0x05), keeps
// WEL/WIP, times a sector erase and reports erase start/done upstream.
//
// Ports:
//   sys_clk      in   system clock (sck half-period >= SYNC_STAGES+2 cycles)
//   sys_rst      in   asynchronous reset, active-high
//   sck          in   SPI clock from master, idle low
//   cs_n         in   SPI chip select, active-low
//   mosi         in   SPI data from master
//   miso         out  SPI data to master, 0 outside the RDSR output phase
//   wel          out  write-enable latch
//   wip          out  erase in progress
//   erase_start  out  1-cycle pulse when an accepted SE begins
//   erase_addr   out  address of the last accepted SE
//   erase_done   out  1-cycle pulse when the erase timer expires
//   cmd_err      out  1-cycle pulse when a framed command is rejected

module flash_se_resp #(
  parameter int SYNC_STAGES  = 2,
  parameter int ERASE_CYCLES = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        wel,
  output logic        wip,
  output logic        erase_start,
  output logic [23:0] erase_addr,
  output logic        erase_done,
  output logic        cmd_err
);

  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam int         TW      = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_STAT,
    ST_END,
    ST_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_d1_q, cs_d1_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   in_frame, sck_rise, sck_fall, cs_fall, cs_rise;

  logic [5:0]    bit_cnt_q;
  logic [23:0]   shift_q;
  logic [7:0]    op_q;
  logic [7:0]    opcode_next;
  logic [7:0]    tx_sh_q;
  logic [2:0]    tx_cnt_q;
  logic [7:0]    status;
  logic [TW-1:0] timer_q;

  logic        miso_q, wel_q, wip_q, erase_start_q, erase_done_q, cmd_err_q;
  logic [23:0] erase_addr_q;
  logic        wren_ok, se_ok, frame_err;

  assign miso        = miso_q;
  assign wel         = wel_q;
  assign wip         = wip_q;
  assign erase_start = erase_start_q;
  assign erase_addr  = erase_addr_q;
  assign erase_done  = erase_done_q;
  assign cmd_err     = cmd_err_q;

  // Input synchronisers plus one extra sample of sck/cs_n for edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_d1_q    <= 1'b0;
      cs_d1_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_d1_q    <= sck_sync_q[SYNC_STAGES-1];
      cs_d1_q     <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  // sck activity only counts while the frame is selected
  assign in_frame    = ~cs_s;
  assign sck_rise    = in_frame & sck_s & ~sck_d1_q;
  assign sck_fall    = in_frame & ~sck_s & sck_d1_q;
  assign cs_fall     = ~cs_s & cs_d1_q;
  assign cs_rise     = cs_s & ~cs_d1_q;
  assign opcode_next = {shift_q[6:0], mosi_s};
  assign status      = {6'b0, wel_q, wip_q};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (sck_rise && bit_cnt_q == 6'd7) begin
          case (opcode_next)
            OP_RDSR: state_d = ST_STAT;
            OP_SE:   state_d = ST_ADDR;
            OP_WREN: state_d = ST_END;
            default: state_d = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: if (sck_rise && bit_cnt_q == 6'd31) state_d = ST_END;
      default: state_d = state_q;
    endcase
    if (cs_rise) state_d = ST_IDLE;
  end

  // Frame commit. ST_END is reached only by WREN or a complete SE, so op_q
  // distinguishes the two; any extra bits show up in the bit count.
  always_comb begin
    wren_ok   = 1'b0;
    se_ok     = 1'b0;
    frame_err = 1'b0;
    if (cs_rise && bit_cnt_q != 6'd0) begin
      case (state_q)
        ST_STAT: begin end
        ST_END: begin
          if (op_q == OP_WREN) begin
            if (bit_cnt_q == 6'd8 && !wip_q) wren_ok = 1'b1;
            else                             frame_err = 1'b1;
          end else begin
            if (bit_cnt_q == 6'd32 && wel_q && !wip_q) se_ok = 1'b1;
            else                                       frame_err = 1'b1;
          end
        end
        default: frame_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      op_q          <= '0;
      tx_sh_q       <= '0;
      tx_cnt_q      <= '0;
      timer_q       <= '0;
      miso_q        <= 1'b0;
      wel_q         <= 1'b0;
      wip_q         <= 1'b0;
      erase_start_q <= 1'b0;
      erase_addr_q  <= '0;
      erase_done_q  <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      if (cs_fall) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
        op_q      <= '0;
      end else if (sck_rise) begin
        if (bit_cnt_q != 6'd63) bit_cnt_q <= bit_cnt_q + 6'd1;
        shift_q <= {shift_q[22:0], mosi_s};
        if (state_q == ST_CMD && bit_cnt_q == 6'd7) op_q <= opcode_next;
      end

      // Status byte is re-captured at every byte boundary so a long RDSR
      // frame tracks live wel/wip.
      if (cs_fall) begin
        tx_sh_q  <= '0;
        tx_cnt_q <= '0;
      end
      if (state_q != ST_STAT) begin
        miso_q <= 1'b0;
      end else if (sck_fall) begin
        if (tx_cnt_q == 3'd0) begin
          miso_q  <= status[7];
          tx_sh_q <= {status[6:0], 1'b0};
        end else begin
          miso_q  <= tx_sh_q[7];
          tx_sh_q <= {tx_sh_q[6:0], 1'b0};
        end
        tx_cnt_q <= tx_cnt_q + 3'd1;
      end

      cmd_err_q     <= frame_err;
      erase_start_q <= se_ok;
      erase_done_q  <= 1'b0;
      if (wren_ok) wel_q <= 1'b1;
      if (se_ok) begin
        erase_addr_q <= shift_q;
        wip_q        <= 1'b1;
        wel_q        <= 1'b0;
        timer_q      <= TW'(ERASE_CYCLES - 1);
      end else if (wip_q) begin
        if (timer_q == '0) begin
          wip_q        <= 1'b0;
          erase_done_q <= 1'b1;
        end else begin
          timer_q <= timer_q - TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_se_resp.sv
// tb/tb_flash_se_resp.sv - self-checking bench for flash_se_resp
module tb_flash_se_resp;

  localparam int ERASE = 600;
  localparam int HALF  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, wel, wip, erase_start, erase_done, cmd_err;
  logic [23:0] erase_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_start = 0, n_done = 0, n_err = 0;
  int t_start = 0, t_done = 0;

  logic        m_wel = 1'b0;
  logic        m_wip = 1'b0;
  logic [23:0] m_addr = '0;

  flash_se_resp #(.SYNC_STAGES(2), .ERASE_CYCLES(ERASE)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .wel        (wel),
    .wip        (wip),
    .erase_start(erase_start),
    .erase_addr (erase_addr),
    .erase_done (erase_done),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (erase_start) begin n_start++; t_start = cyc; end
    if (erase_done)  begin n_done++;  t_done  = cyc; end
    if (cmd_err)     n_err++;
  end

  // Bits are left-aligned: bits[63] goes out first; rx captures miso just
  // before each sck rise, left-aligned the same way.
  task automatic spi_frame(input logic [63:0] bits, input int n, output logic [63:0] rx);
    rx = '0;
    @(negedge clk) cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mosi = bits[63-i];
      repeat (HALF) @(negedge clk);
      rx[63-i] = miso;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (HALF + 6) @(negedge clk);
  endtask

  // Frame-level rules: 0 silent, 1 WREN accepted, 2 SE accepted, 3 rejected.
  task automatic model_commit(input logic [63:0] bits, input int n, output int res);
    logic [7:0] op;
    op = bits[63:56];
    if (n == 0) res = 0;
    else if (n < 8) res = 3;
    else if (op == 8'h05) res = 0;
    else if (op == 8'h06) begin
      if (n == 8 && !m_wip) begin m_wel = 1'b1; res = 1; end
      else res = 3;
    end else if (op == 8'hD8) begin
      if (n == 32 && m_wel && !m_wip) begin
        m_addr = bits[55:32];
        m_wip  = 1'b1;
        m_wel  = 1'b0;
        res    = 2;
      end else res = 3;
    end else res = 3;
  endtask

  task automatic wait_done();
    int d0;
    d0 = n_done;
    for (int k = 0; k < ERASE + 100 && n_done == d0; k++) @(negedge clk);
    total++;
    if (n_done != d0 + 1) begin
      bad++; $display("FAIL erase_done_count got=%0d want=%0d", n_done - d0, 1);
    end
    total++;
    if (t_done - t_start != ERASE) begin
      bad++; $display("FAIL erase_duration got=%0d want=%0d", t_done - t_start, ERASE);
    end
    total++;
    if (wip !== 1'b0) begin
      bad++; $display("FAIL wip_after_done got=%b want=0", wip);
    end
    m_wip = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({miso, wel, wip, erase_start, erase_addr, erase_done, cmd_err} !== 30'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
                      {miso, wel, wip, erase_start, erase_addr, erase_done, cmd_err});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (n_err != 0) begin
      bad++; $display("FAIL reset_no_err got=%0d want=0", n_err);
    end
  endtask

  task automatic test_wren_se();
    logic [63:0] rx;
    int res, s0;
    spi_frame({8'h06, 56'h0}, 8, rx);
    model_commit({8'h06, 56'h0}, 8, res);
    total++;
    if (wel !== m_wel) begin bad++; $display("FAIL t1_wel got=%b want=%b", wel, m_wel); end
    s0 = n_start;
    spi_frame({32'hD8000425, 32'h0}, 32, rx);
    model_commit({32'hD8000425, 32'h0}, 32, res);
    total++;
    if (n_start != s0 + 1) begin bad++; $display("FAIL t1_start got=%0d want=1", n_start - s0); end
    total++;
    if (erase_addr !== 24'h000425) begin bad++; $display("FAIL t1_addr got=%h want=000425", erase_addr); end
    total++;
    if ({wip, wel} !== {m_wip, m_wel}) begin
      bad++; $display("FAIL t1_wip_wel got=%b%b want=%b%b", wip, wel, m_wip, m_wel);
    end
    wait_done();
  endtask

  task automatic test_se_no_wren();
    logic [63:0] rx;
    int res, s0, e0;
    s0 = n_start; e0 = n_err;
    spi_frame({32'hD8000425, 32'h0}, 32, rx);
    model_commit({32'hD8000425, 32'h0}, 32, res);
    total++;
    if (n_err - e0 != 1) begin bad++; $display("FAIL t2_err got=%0d want=1", n_err - e0); end
    total++;
    if (n_start != s0) begin bad++; $display("FAIL t2_start got=%0d want=0", n_start - s0); end
    total++;
    if (wip !== 1'b0) begin bad++; $display("FAIL t2_wip got=%b want=0", wip); end
  endtask

  task automatic test_rdsr();
    logic [63:0] rx;
    int res;
    spi_frame({8'h06, 56'h0}, 8, rx);
    model_commit({8'h06, 56'h0}, 8, res);
    spi_frame({8'h05, 56'h0}, 24, rx);
    total++;
    if (rx[55:40] !== 16'h0202) begin bad++; $display("FAIL t3_rdsr_wel got=%h want=0202", rx[55:40]); end
    spi_frame({32'hD8123456, 32'h0}, 32, rx);
    model_commit({32'hD8123456, 32'h0}, 32, res);
    spi_frame({8'h05, 56'h0}, 16, rx);
    total++;
    if (rx[55:48] !== 8'h01) begin bad++; $display("FAIL t3_rdsr_wip got=%h want=01", rx[55:48]); end
    wait_done();
  endtask

  task automatic test_abort();
    logic [63:0] rx;
    int res, e0;
    spi_frame({8'h06, 56'h0}, 8, rx);
    model_commit({8'h06, 56'h0}, 8, res);
    e0 = n_err;
    spi_frame({32'hD8010000, 32'h0}, 20, rx);
    model_commit({32'hD8010000, 32'h0}, 20, res);
    total++;
    if (n_err - e0 != 1) begin bad++; $display("FAIL t4_err got=%0d want=1", n_err - e0); end
    total++;
    if (wel !== 1'b1) begin bad++; $display("FAIL t4_wel got=%b want=1", wel); end
    total++;
    if (erase_addr !== m_addr) begin bad++; $display("FAIL t4_addr_kept got=%h want=%h", erase_addr, m_addr); end
    spi_frame({32'hD8010000, 32'h0}, 32, rx);
    model_commit({32'hD8010000, 32'h0}, 32, res);
    total++;
    if (erase_addr !== 24'h010000) begin bad++; $display("FAIL t4_addr got=%h want=010000", erase_addr); end
    wait_done();
  endtask

  task automatic test_wren_busy();
    logic [63:0] rx;
    int res, e0;
    spi_frame({8'h06, 56'h0}, 8, rx);
    model_commit({8'h06, 56'h0}, 8, res);
    spi_frame({32'hD8ABCDEF, 32'h0}, 32, rx);
    model_commit({32'hD8ABCDEF, 32'h0}, 32, res);
    e0 = n_err;
    spi_frame({8'h06, 56'h0}, 8, rx);
    model_commit({8'h06, 56'h0}, 8, res);
    total++;
    if (n_err - e0 != 1) begin bad++; $display("FAIL t5_err got=%0d want=1", n_err - e0); end
    total++;
    if ({wel, wip} !== 2'b01) begin bad++; $display("FAIL t5_wel_wip got=%b%b want=01", wel, wip); end
    wait_done();
  endtask

  task automatic test_reset_mid_erase();
    logic [63:0] rx;
    int res, d0;
    spi_frame({8'h06, 56'h0}, 8, rx);
    model_commit({8'h06, 56'h0}, 8, res);
    spi_frame({32'hD8055AA5, 32'h0}, 32, rx);
    model_commit({32'hD8055AA5, 32'h0}, 32, res);
    while (cyc < t_start + 10) @(negedge clk);
    d0 = n_done;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({miso, wel, wip, erase_start, erase_addr, erase_done, cmd_err} !== 30'd0) begin
      bad++; $display("FAIL t6_reset_outputs got=%h want=0",
                      {miso, wel, wip, erase_start, erase_addr, erase_done, cmd_err});
    end
    rst = 1'b0;
    m_wel = 1'b0; m_wip = 1'b0; m_addr = '0;
    repeat (ERASE + 50) @(negedge clk);
    total++;
    if (n_done != d0) begin bad++; $display("FAIL t6_no_done got=%0d want=0", n_done - d0); end
    spi_frame({8'h05, 56'h0}, 16, rx);
    total++;
    if (rx[55:48] !== 8'h00) begin bad++; $display("FAIL t6_rdsr got=%h want=00", rx[55:48]); end
  endtask

  task automatic test_random();
    logic [63:0] bits, rx, exp_rx, mask;
    logic [7:0]  st, op;
    int n, kind, res, e0, s0, busy;
    busy = 0;
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 5);
      if (m_wip && busy >= 1) kind = 5;
      bits = {$urandom, $urandom};
      n = 0;
      case (kind)
        0: begin bits[63:56] = 8'h06; n = 8; end
        1: begin bits[63:56] = 8'hD8; n = 32; end
        2: begin bits[63:56] = 8'h05; n = 8 * $urandom_range(2, 3); end
        3: begin
          op = 8'($urandom);
          while (op == 8'h05 || op == 8'h06 || op == 8'hD8) op = 8'($urandom);
          bits[63:56] = op;
          n = $urandom_range(8, 16);
        end
        4: begin bits[63:56] = ($urandom_range(0, 1) != 0) ? 8'h06 : 8'hD8; n = $urandom_range(1, 31); end
        default: n = 0;
      endcase
      if (kind == 5 && m_wip) begin
        wait_done();
        busy = 0;
      end else begin
        st = {6'b0, m_wel, m_wip};
        e0 = n_err; s0 = n_start;
        spi_frame(bits, n, rx);
        model_commit(bits, n, res);
        if (res == 2) busy = 0;
        else if (m_wip) busy++;
        total++;
        if (n_err - e0 != ((res == 3) ? 1 : 0)) begin
          bad++; $display("FAIL rnd_err it=%0d op=%h n=%0d got=%0d want=%0d", it, bits[63:56], n, n_err - e0, res == 3);
        end
        total++;
        if (n_start - s0 != ((res == 2) ? 1 : 0)) begin
          bad++; $display("FAIL rnd_start it=%0d got=%0d want=%0d", it, n_start - s0, res == 2);
        end
        total++;
        if ({wel, wip, erase_addr} !== {m_wel, m_wip, m_addr}) begin
          bad++; $display("FAIL rnd_state it=%0d got=%b%b_%h want=%b%b_%h", it, wel, wip, erase_addr, m_wel, m_wip, m_addr);
        end
        if (kind == 2) begin
          exp_rx = '0; mask = '0;
          for (int i = 8; i < n; i++) begin
            mask[63-i]   = 1'b1;
            exp_rx[63-i] = st[7-((i-8)%8)];
          end
          total++;
          if ((rx & mask) !== exp_rx) begin
            bad++; $display("FAIL rnd_rdsr it=%0d got=%h want=%h", it, rx & mask, exp_rx);
          end
        end
      end
    end
    if (m_wip) wait_done();
  endtask

  initial begin
    test_reset();
    test_wren_se();
    test_se_no_wren();
    test_rdsr();
    test_abort();
    test_wren_busy();
    test_reset_mid_erase();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
